feature_collector: RTL and testbench
====================================

Name: feature_collector

Overview:
- Downstream stage of FD_top; consumes its feature-result stream (in_feature_valid / in_isfeature / in_feature_addr).
- Buffers detected-feature addresses in a FIFO and drives FD_top's ready_for_new_feature input.
- Streams addresses out over a valid/ready interface, appending an end-of-frame marker beat on flush.
- Keeps saturating statistics counters for the simulation bench and later host readout.

Parameters:
- ADDR_WIDTH, 16, width of feature address and output data.
- FIFO_DEPTH, 64, FIFO entries; power of two, >= 4.
- CNT_WIDTH, 32, width of statistics counters.
- KEEP_NONFEATURE, 0, 1 = also store results with isfeature=0; 0 = discard them.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-high; name kept for port compatibility with FD_top/dispatcher wiring.
- in_feature_valid  in  1  result beat from FD_top.
- in_isfeature  in  1  beat is a detected feature.
- in_feature_addr  in  ADDR_WIDTH  pixel address of beat.
- out_ready_for_new_feature  out  1  registered backpressure to FD_top.
- frame_flush  in  1  one-cycle pulse: end of frame, drain and emit marker.
- clr_counters  in  1  one-cycle pulse: clear counters and overflow flag.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts beat.
- m_addr  out  ADDR_WIDTH  feature address, or frame feature count on a marker beat.
- m_isfeature  out  1  stored isfeature bit; 0 on a marker beat.
- m_last  out  1  marker beat.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- cnt_total  out  CNT_WIDTH  result beats seen.
- cnt_feature  out  CNT_WIDTH  beats with isfeature=1.
- cnt_dropped  out  CNT_WIDTH  storable beats lost to a full FIFO.
- overflow  out  1  sticky; set on any drop.

Behaviour:
- Reset, while rst_n=1:
  - all outputs 0; FIFO emptied; FSM in RUN.
  - out_ready_for_new_feature rises in the first cycle after reset deasserts.
  - Reset mid-operation discards FIFO contents and any pending output beat.
- Storable beat: in_feature_valid & (in_isfeature | KEEP_NONFEATURE).
  - Written at the clock edge ending its cycle if the FIFO is not full, or is full and a pop occurs in the same cycle. Otherwise it is dropped.
  - Each drop increments cnt_dropped and sets overflow.
  - Input beats are accepted regardless of out_ready_for_new_feature; ready is advisory throttling only.
- Ready: registered, out_ready_for_new_feature <= (next level <= FIFO_DEPTH-2) & state==RUN. The 2-entry slack covers the one-cycle ready latency.
- Output stage: one register slice fed from the FIFO head.
  - m_valid / m_addr / m_isfeature / m_last hold stable while m_valid & !m_ready.
  - Latency: empty pipeline, beat at cycle N -> m_valid high at cycle N+2.
  - Sustained throughput is 1 beat/cycle with m_ready=1.
- FSM states:
  - RUN: normal operation. frame_flush -> DRAIN.
  - DRAIN: ready forced 0; storable beats still written if space. When FIFO empty, output slice empty, and no write this cycle -> EOF.
  - EOF: present marker beat: m_last=1, m_isfeature=0, m_addr = frame_feature_count truncated to ADDR_WIDTH. On m_ready, clear frame_feature_count -> RUN.
- frame_flush outside RUN is ignored.
- frame_feature_count: internal ADDR_WIDTH-bit counter of stored isfeature=1 beats; saturates at all-ones.
- Counters:
  - cnt_total increments on every in_feature_valid; cnt_feature on every in_feature_valid & in_isfeature.
  - All counters saturate at 2^CNT_WIDTH-1.
  - clr_counters zeroes cnt_* and overflow; clear wins over a same-cycle increment.
  - clr_counters does not touch the FIFO or frame_feature_count.
- fifo_level: registered occupancy excluding the output slice. A simultaneous push and pop leaves it unchanged.

Decomposition:
- Shared package/header fd_pkg:
  - FSM state encodings RUN/DRAIN/EOF.
  - ADDR_WIDTH default 16.
  - Saturating-increment function.
- Sub-module sync_fifo:
  - Parameters: width, depth.
  - Ports: push, pop, full, empty, level.
  - Single-cycle registered read.
  - Reusable by the dispatcher side later.

Test Plan:
- Basic stream: 5 beats isfeature=1, addrs 0x0010..0x0014, m_ready=1 -> same addrs in order on m_addr, first m_valid 2 cycles after first input; cnt_total=5, cnt_feature=5.
- Filtering, KEEP_NONFEATURE=0: alternating isfeature 1/0 over 8 beats -> 4 output beats; cnt_total=8, cnt_feature=4, fifo_level returns to 0.
- Backpressure and overflow, FIFO_DEPTH=8, m_ready=0: 12 feature beats back-to-back -> ready falls once level reaches 7 (registered, one cycle later); cnt_dropped=3, overflow=1; m_addr holds the first address throughout.
- Flush: 3 features then frame_flush with m_ready=1 -> 3 address beats, then one beat with m_last=1, m_addr=0x0003; ready low during DRAIN/EOF, back high after the marker.
- Push/pop at full, FIFO_DEPTH=8: FIFO full, m_ready=1, simultaneous input beat -> accepted, cnt_dropped unchanged, level stays 8.
- Reset and clear: rst_n pulsed with 4 entries queued -> m_valid=0, level 0, ready high one cycle later. clr_counters in the same cycle as a feature beat -> counters read 0 next cycle.

Source files
------------

// File: rtl/fd_pkg.sv
// Shared definitions for the feature-detection pipeline.
// Contents:
//   ADDR_WIDTH_DEFAULT : default feature address width
//   fc_state_t         : feature collector FSM states (RUN / DRAIN / EOF)
//   sat_inc()          : saturating increment for counters up to 64 bits wide
package fd_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        EOF   = 2'd2
    } fc_state_t;

    // Increment value, holding at the all-ones value of a width-bit counter.
    // Callers widen their counter to 64 bits and truncate the result back.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input int unsigned width);
        logic [63:0] max_value;
        max_value = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_value) ? max_value : value + 64'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port.
// Ports:
//   clk, rst_n   : clock; synchronous active-high reset
//   push, wdata  : write request and data (ignored when full without a pop)
//   pop, rdata   : read request; rdata updates at the edge ending a pop cycle
//                  and holds until the next pop
//   full, empty  : occupancy flags
//   level        : number of stored entries (excludes the read register)
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    // A write into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // NOTE: the storage array carries no reset; only pointers, level and the
    // read register need a known value, and an un-reset array maps to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                rdata  <= mem[rd_ptr];
            end
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/feature_collector.sv
// Collects detected-feature addresses from FD_top, buffers them and streams
// them downstream, closing each frame with a marker beat carrying the frame's
// feature count.
// Ports:
//   clk, rst_n                 : clock; synchronous active-high reset
//   in_feature_valid/in_isfeature/in_feature_addr : result beats from FD_top
//   out_ready_for_new_feature  : registered, advisory backpressure to FD_top
//   frame_flush                : end-of-frame pulse (drain, then marker beat)
//   clr_counters               : clears statistics counters and overflow
//   m_valid/m_ready/m_addr/m_isfeature/m_last : output stream
//   fifo_level                 : FIFO occupancy (excluding output slice)
//   cnt_total/cnt_feature/cnt_dropped/overflow : saturating statistics
module feature_collector
    import fd_pkg::*;
#(
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH      = 64,
    parameter int CNT_WIDTH       = 32,
    parameter int KEEP_NONFEATURE = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_feature_valid,
    input  logic                          in_isfeature,
    input  logic [ADDR_WIDTH-1:0]         in_feature_addr,
    output logic                          out_ready_for_new_feature,
    input  logic                          frame_flush,
    input  logic                          clr_counters,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [ADDR_WIDTH-1:0]         m_addr,
    output logic                          m_isfeature,
    output logic                          m_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]          cnt_total,
    output logic [CNT_WIDTH-1:0]          cnt_feature,
    output logic [CNT_WIDTH-1:0]          cnt_dropped,
    output logic                          overflow
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    fc_state_t               state;
    fc_state_t               next_state;
    logic                    slice_valid;
    logic [ADDR_WIDTH:0]     head_data;
    logic [ADDR_WIDTH-1:0]   marker_addr;
    logic [ADDR_WIDTH-1:0]   frame_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    storable;
    logic                    push;
    logic                    pop;
    logic                    drop;
    logic                    feature_push;
    logic [LW-1:0]           next_level;
    logic                    ready_next;

    // The FIFO read register doubles as the output slice: slice_valid marks
    // whether it currently holds an unaccepted beat.
    sync_fifo #(
        .WIDTH (ADDR_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({in_isfeature, in_feature_addr}),
        .pop   (pop),
        .rdata (head_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // NOTE: every combinational output gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        storable     = in_feature_valid & (in_isfeature | (KEEP_NONFEATURE != 0));
        // Refill the slice when it is empty or its beat leaves this cycle; the
        // marker owns the output while in EOF.
        pop          = ~fifo_empty & (~slice_valid | m_ready) & (state != EOF);
        push         = storable & (~fifo_full | pop);
        drop         = storable & ~push;
        feature_push = push & in_isfeature;
        next_level   = fifo_level + LW'(push) - LW'(pop);
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (frame_flush) next_state = DRAIN;
            DRAIN:   if (fifo_empty & ~slice_valid & ~push) next_state = EOF;
            EOF:     if (m_ready) next_state = RUN;
            default: next_state = RUN;
        endcase
        // Two entries of slack absorb a beat already in flight when ready drops.
        ready_next = (next_level <= LW'(FIFO_DEPTH - 2)) & (next_state == RUN);
    end

    assign m_valid     = slice_valid | (state == EOF);
    assign m_last      = (state == EOF);
    assign m_addr      = (state == EOF) ? marker_addr : head_data[ADDR_WIDTH-1:0];
    assign m_isfeature = (state == EOF) ? 1'b0 : head_data[ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state                     <= RUN;
            slice_valid               <= 1'b0;
            out_ready_for_new_feature <= 1'b0;
            marker_addr               <= '0;
            frame_count               <= '0;
            cnt_total                 <= '0;
            cnt_feature               <= '0;
            cnt_dropped               <= '0;
            overflow                  <= 1'b0;
        end else begin
            state                     <= next_state;
            out_ready_for_new_feature <= ready_next;

            if (pop) begin
                slice_valid <= 1'b1;
            end else if (m_ready) begin
                slice_valid <= 1'b0;
            end

            // Latch the count on entry to EOF so the marker stays stable even
            // if further features arrive while it waits for m_ready.
            if ((state == DRAIN) && (next_state == EOF)) begin
                marker_addr <= frame_count;
            end

            if ((state == EOF) && m_ready) begin
                frame_count <= feature_push ? ADDR_WIDTH'(1) : '0;
            end else if (feature_push) begin
                frame_count <= ADDR_WIDTH'(sat_inc(64'(frame_count), ADDR_WIDTH));
            end

            if (clr_counters) begin
                cnt_total   <= '0;
                cnt_feature <= '0;
                cnt_dropped <= '0;
                overflow    <= 1'b0;
            end else begin
                if (in_feature_valid) begin
                    cnt_total <= CNT_WIDTH'(sat_inc(64'(cnt_total), CNT_WIDTH));
                end
                if (in_feature_valid & in_isfeature) begin
                    cnt_feature <= CNT_WIDTH'(sat_inc(64'(cnt_feature), CNT_WIDTH));
                end
                if (drop) begin
                    cnt_dropped <= CNT_WIDTH'(sat_inc(64'(cnt_dropped), CNT_WIDTH));
                    overflow    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_feature_collector.sv
// Directed bench for feature_collector (FIFO_DEPTH=8, KEEP_NONFEATURE=0).
// A negedge monitor records every accepted output beat into a queue; each
// scenario then compares the recorded beats and status outputs against
// hand-computed values.
module tb_feature_collector;

    localparam int AW = 16;
    localparam int DEPTH = 8;
    localparam int CW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          isf;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_feature_valid = 1'b0;
    logic            in_isfeature = 1'b0;
    logic [AW-1:0]   in_feature_addr = '0;
    logic            out_ready_for_new_feature;
    logic            frame_flush = 1'b0;
    logic            clr_counters = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [AW-1:0]   m_addr;
    logic            m_isfeature;
    logic            m_last;
    logic [3:0]      fifo_level;
    logic [CW-1:0]   cnt_total;
    logic [CW-1:0]   cnt_feature;
    logic [CW-1:0]   cnt_dropped;
    logic            overflow;

    int    errors = 0;
    int    checks = 0;
    beat_t q[$];

    feature_collector #(
        .ADDR_WIDTH      (AW),
        .FIFO_DEPTH      (DEPTH),
        .CNT_WIDTH       (CW),
        .KEEP_NONFEATURE (0)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .in_feature_valid          (in_feature_valid),
        .in_isfeature              (in_isfeature),
        .in_feature_addr           (in_feature_addr),
        .out_ready_for_new_feature (out_ready_for_new_feature),
        .frame_flush               (frame_flush),
        .clr_counters              (clr_counters),
        .m_valid                   (m_valid),
        .m_ready                   (m_ready),
        .m_addr                    (m_addr),
        .m_isfeature               (m_isfeature),
        .m_last                    (m_last),
        .fifo_level                (fifo_level),
        .cnt_total                 (cnt_total),
        .cnt_feature               (cnt_feature),
        .cnt_dropped               (cnt_dropped),
        .overflow                  (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst_n && m_valid && m_ready) begin
            q.push_back('{addr: m_addr, isf: m_isfeature, last: m_last});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [AW-1:0] a, input logic f);
        in_feature_valid = 1'b1;
        in_isfeature     = f;
        in_feature_addr  = a;
    endtask

    task automatic idle();
        in_feature_valid = 1'b0;
        in_isfeature     = 1'b0;
        in_feature_addr  = '0;
    endtask

    task automatic do_reset();
        idle();
        frame_flush  = 1'b0;
        clr_counters = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    task automatic check_queue(input string tag, input int idx,
                               input logic [AW-1:0] addr, input logic last);
        if (idx < q.size()) begin
            check({tag, "_addr"}, 64'(q[idx].addr), 64'(addr));
            check({tag, "_last"}, 64'(q[idx].last), 64'(last));
        end else begin
            check({tag, "_present"}, 64'(q.size()), 64'(idx + 1));
        end
    endtask

    task automatic wait_marker(input string tag);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            foreach (q[k]) if (q[k].last) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        // Reset state
        idle();
        tick();
        tick();
        check("rst_m_valid", 64'(m_valid), 0);
        check("rst_m_last", 64'(m_last), 0);
        check("rst_level", 64'(fifo_level), 0);
        check("rst_ready", 64'(out_ready_for_new_feature), 0);
        check("rst_cnt_total", 64'(cnt_total), 0);
        check("rst_overflow", 64'(overflow), 0);
        rst_n = 1'b0;
        tick();
        check("rst_ready_rise", 64'(out_ready_for_new_feature), 1);

        // Basic stream with 2-cycle latency
        do_reset();
        m_ready = 1'b1;
        q.delete();
        for (int i = 0; i < 5; i++) begin
            drive_beat(AW'(16'h0010 + i), 1'b1);
            tick();
            if (i == 0) check("t1_latency_n1", 64'(m_valid), 0);
            if (i == 1) begin
                check("t1_latency_n2", 64'(m_valid), 1);
                check("t1_first_addr", 64'(m_addr), 64'h10);
            end
        end
        idle();
        repeat (6) tick();
        check("t1_beats", 64'(q.size()), 5);
        for (int i = 0; i < 5; i++) check_queue("t1_beat", i, AW'(16'h0010 + i), 1'b0);
        check("t1_cnt_total", 64'(cnt_total), 5);
        check("t1_cnt_feature", 64'(cnt_feature), 5);

        // Filtering of non-feature beats
        do_reset();
        m_ready = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            drive_beat(AW'(16'h0020 + i), (i % 2) == 0);
            tick();
        end
        idle();
        repeat (6) tick();
        check("t2_beats", 64'(q.size()), 4);
        for (int i = 0; i < 4; i++) check_queue("t2_beat", i, AW'(16'h0020 + 2 * i), 1'b0);
        check("t2_cnt_total", 64'(cnt_total), 8);
        check("t2_cnt_feature", 64'(cnt_feature), 4);
        check("t2_level", 64'(fifo_level), 0);

        // Backpressure and overflow
        do_reset();
        m_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 12; i++) begin
            int exp_level;
            drive_beat(AW'(16'h0030 + i), 1'b1);
            tick();
            exp_level = (i == 0) ? 1 : ((i > 8) ? 8 : i);
            check($sformatf("t3_level_%0d", i), 64'(fifo_level), 64'(exp_level));
            check($sformatf("t3_ready_%0d", i), 64'(out_ready_for_new_feature),
                  64'(exp_level <= 6));
            check($sformatf("t3_hold_%0d", i), 64'(m_addr), (i == 0) ? 64'h0 : 64'h30);
        end
        idle();
        tick();
        check("t3_dropped", 64'(cnt_dropped), 3);
        check("t3_overflow", 64'(overflow), 1);
        check("t3_m_valid", 64'(m_valid), 1);
        check("t3_m_addr", 64'(m_addr), 64'h30);
        check("t3_cnt_total", 64'(cnt_total), 12);
        check("t3_no_beats", 64'(q.size()), 0);

        // Push and pop together while full
        q.delete();
        m_ready = 1'b1;
        drive_beat(16'h0050, 1'b1);
        tick();
        idle();
        m_ready = 1'b0;
        check("t5_level", 64'(fifo_level), 8);
        check("t5_dropped", 64'(cnt_dropped), 3);
        check("t5_m_addr", 64'(m_addr), 64'h31);
        tick();
        check("t5_m_addr_hold", 64'(m_addr), 64'h31);
        m_ready = 1'b1;
        repeat (14) tick();
        check("t5_beats", 64'(q.size()), 10);
        for (int i = 0; i < 9; i++) check_queue("t5_beat", i, AW'(16'h0030 + i), 1'b0);
        check_queue("t5_tail", 9, 16'h0050, 1'b0);
        check("t5_level_empty", 64'(fifo_level), 0);

        // Counter clear wins over a same-cycle beat
        drive_beat(16'h0070, 1'b1);
        clr_counters = 1'b1;
        tick();
        idle();
        clr_counters = 1'b0;
        check("clr_total", 64'(cnt_total), 0);
        check("clr_feature", 64'(cnt_feature), 0);
        check("clr_dropped", 64'(cnt_dropped), 0);
        check("clr_overflow", 64'(overflow), 0);
        repeat (4) tick();

        // Flush with end-of-frame marker
        do_reset();
        m_ready = 1'b1;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            drive_beat(AW'(16'h0040 + i), 1'b1);
            tick();
        end
        idle();
        frame_flush = 1'b1;
        tick();
        frame_flush = 1'b0;
        check("t4_ready_drain", 64'(out_ready_for_new_feature), 0);
        wait_marker("t4_marker_seen");
        check("t4_ready_after", 64'(out_ready_for_new_feature), 1);
        check("t4_beats", 64'(q.size()), 4);
        for (int i = 0; i < 3; i++) check_queue("t4_beat", i, AW'(16'h0040 + i), 1'b0);
        check_queue("t4_marker", 3, 16'h0003, 1'b1);
        if (q.size() > 3) check("t4_marker_isf", 64'(q[3].isf), 0);

        // A second empty frame reports a zero count
        q.delete();
        frame_flush = 1'b1;
        tick();
        frame_flush = 1'b0;
        wait_marker("t4b_marker_seen");
        check_queue("t4b_marker", 0, 16'h0000, 1'b1);

        // Reset with entries queued
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_beat(AW'(16'h0060 + i), 1'b1);
            tick();
        end
        idle();
        check("t6_level_before", 64'(fifo_level), 3);
        check("t6_valid_before", 64'(m_valid), 1);
        rst_n = 1'b1;
        tick();
        check("t6_m_valid", 64'(m_valid), 0);
        check("t6_level", 64'(fifo_level), 0);
        check("t6_ready_in_reset", 64'(out_ready_for_new_feature), 0);
        check("t6_cnt_total", 64'(cnt_total), 0);
        rst_n = 1'b0;
        tick();
        check("t6_ready_rise", 64'(out_ready_for_new_feature), 1);
        tick();
        check("t6_no_stale_beat", 64'(m_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
